// File: rtl/isa_types.sv
// isa_types: XLEN, load width encodings and load-decoding helpers shared by the load path.
package isa_types;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_width_t;
  function automatic logic legal_load(input logic [2:0] f);
    return f inside {LB, LH, LW, LBU, LHU};
  endfunction
  // sz is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic crosses_word(input logic [1:0] off, input logic [1:0] sz);
    return ({1'b0, off} + (sz[1] ? 3'd4 : sz[0] ? 3'd2 : 3'd1)) > 3'd4;
  endfunction
endpackage

// File: rtl/load_unit_if.sv
// load_unit_if: request/response and memory read signals of the load stage.
interface load_unit_if;
  import isa_types::*;
  logic            enable;
  logic [XLEN-1:0] addr;
  logic [2:0]      funct3;
  logic [XLEN-1:0] mem_addr;
  logic            mem_read_enable;
  logic [XLEN-1:0] mem_rdata;
  logic            is_complete;
  logic [XLEN-1:0] load_val;
  logic            load_fault;
  modport slave (
    input  enable, addr, funct3, mem_rdata,
    output mem_addr, mem_read_enable, is_complete, load_val, load_fault
  );
  modport master (
    output enable, addr, funct3, mem_rdata,
    input  mem_addr, mem_read_enable, is_complete, load_val, load_fault
  );
endinterface

// File: rtl/load_unit_extract.sv
// load_extract: selects the addressed bytes from a two-word window and sign/zero extends them.
module load_extract import isa_types::*; (
  input  logic [63:0]     pair,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value
);
  logic [31:0] w;
  assign w = 32'(pair >> {offset, 3'b000});
  always_comb
    value = funct3 == LB  ? {{(XLEN-8){w[7]}}, w[7:0]} :
            funct3 == LH  ? {{(XLEN-16){w[15]}}, w[15:0]} :
            funct3 == LBU ? XLEN'(w[7:0]) :
            funct3 == LHU ? XLEN'(w[15:0]) : XLEN'(w);
endmodule

// File: rtl/load_unit.sv
// load_unit: multi-cycle load stage with fixed-latency memory reads.
// Define LOAD_UNIT_MISALIGNED_EN to service word-crossing loads with a second read.
module load_unit import isa_types::*; #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic        clock,
  input logic        reset,
  load_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI, DONE} state_t;
  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d, lo_q, lo_d, val_q, val_d, hi_sel, ext;
  logic [1:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic            fault_q, fault_d, cap;
`ifdef LOAD_UNIT_MISALIGNED_EN
  logic [XLEN-1:0] hi_q, hi_d;
  assign hi_sel = state_q == WAIT_HI ? bus.mem_rdata : hi_q;
`else
  assign hi_sel = '0;
`endif
  assign cap = cnt_q == 4'd1;
  load_extract u_extract (
    .pair  ({hi_sel, state_q == WAIT_LO ? bus.mem_rdata : lo_q}),
    .offset(off_q),
    .funct3(f3_q),
    .value (ext)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    val_d   = val_q;
    off_d   = off_q;
    f3_d    = f3_q;
    fault_d = fault_q;
`ifdef LOAD_UNIT_MISALIGNED_EN
    hi_d    = hi_q;
`endif
    case (state_q)
      IDLE: if (bus.enable) begin
        off_d = bus.addr[1:0];
        f3_d  = bus.funct3;
        if (legal_load(bus.funct3)) begin
          state_d = WAIT_LO;
          addr_d  = {bus.addr[XLEN-1:2], 2'b00};
          cnt_d   = 4'(MEM_LATENCY);
          fault_d = 1'b0;
        end else begin
          state_d = DONE;
          fault_d = 1'b1;
          val_d   = '0;
        end
      end
      WAIT_LO: if (!bus.enable) begin
        state_d = IDLE;
        cnt_d   = '0;
        lo_d    = '0;
      end else begin
        cnt_d = cnt_q - 4'd1;
        if (cap) begin
          lo_d = bus.mem_rdata;
          if (crosses_word(off_q, f3_q[1:0])) begin
`ifdef LOAD_UNIT_MISALIGNED_EN
            // one turnaround cycle before the second read so crossing costs 2*L+2
            state_d = WAIT_HI;
            addr_d  = addr_q + XLEN'(4);
            cnt_d   = 4'(MEM_LATENCY + 1);
`else
            state_d = DONE;
            fault_d = 1'b1;
            val_d   = '0;
`endif
          end else begin
            state_d = DONE;
            val_d   = ext;
          end
        end
      end
`ifdef LOAD_UNIT_MISALIGNED_EN
      WAIT_HI: if (!bus.enable) begin
        state_d = IDLE;
        cnt_d   = '0;
        lo_d    = '0;
        hi_d    = '0;
      end else begin
        cnt_d = cnt_q - 4'd1;
        if (cap) begin
          hi_d    = bus.mem_rdata;
          state_d = DONE;
          val_d   = ext;
        end
      end
`endif
      DONE: if (!bus.enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      lo_q    <= '0;
      val_q   <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      fault_q <= 1'b0;
`ifdef LOAD_UNIT_MISALIGNED_EN
      hi_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      val_q   <= val_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      fault_q <= fault_d;
`ifdef LOAD_UNIT_MISALIGNED_EN
      hi_q    <= hi_d;
`endif
    end
  assign bus.mem_read_enable = state_q == WAIT_LO || state_q == WAIT_HI;
  assign bus.mem_addr        = bus.mem_read_enable ? addr_q : '0;
  assign bus.is_complete     = state_q == DONE;
  assign bus.load_fault      = bus.is_complete & fault_q;
  assign bus.load_val        = val_q;
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed checks of load_unit against a small fixed memory image.
module tb_load_unit;
  import isa_types::*;
  logic        clock = 1'b0, reset;
  int          tests = 0, fails = 0, nrd = 0;
  logic [31:0] rd0, rd1, last_rd;
  logic        comp_seen = 1'b0, re_seen = 1'b0;
  load_unit_if bus();
  load_unit #(.MEM_LATENCY(1)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  assign bus.mem_rdata = bus.mem_addr == 32'h100 ? 32'h88776655 :
                         bus.mem_addr == 32'h104 ? 32'hCCBBAA99 :
                         bus.mem_addr == 32'hFFFFFFFC ? 32'h12345678 :
                         bus.mem_addr == 32'h0 ? 32'h9ABCDEF0 : 32'hDEADBEEF;
  always @(posedge clock) begin
    if (bus.mem_read_enable && (nrd == 0 || last_rd != bus.mem_addr)) begin
      if (nrd == 0) rd0 = bus.mem_addr; else rd1 = bus.mem_addr;
      last_rd = bus.mem_addr;
      nrd++;
    end
    comp_seen = comp_seen | bus.is_complete;
    re_seen   = re_seen | bus.mem_read_enable;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic load(input string tag, input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] v, input logic flt, input int l, input int n);
    int lat = 0;
    nrd = 0;
    bus.addr = a;
    bus.funct3 = f;
    bus.enable = 1'b1;
    do begin
      @(negedge clock);
      lat++;
    end while (!bus.is_complete && lat < 20);
    chk({tag, "_lat"}, 32'(lat), 32'(l));
    chk({tag, "_val"}, bus.load_val, v);
    chk({tag, "_fault"}, 32'(bus.load_fault), 32'(flt));
    chk({tag, "_reads"}, 32'(nrd), 32'(n));
    bus.enable = 1'b0;
    @(negedge clock);
    chk({tag, "_idle"}, {29'b0, bus.is_complete, bus.mem_read_enable, bus.load_fault}, 32'h0);
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_re"}, 32'(bus.mem_read_enable), 32'h0);
    chk({tag, "_addr"}, bus.mem_addr, 32'h0);
    chk({tag, "_cmp"}, 32'(bus.is_complete), 32'h0);
    chk({tag, "_fault"}, 32'(bus.load_fault), 32'h0);
    chk({tag, "_val"}, bus.load_val, 32'h0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.addr = 32'h100;
    bus.funct3 = LW;
    repeat (2) @(negedge clock);
    chk_idle_outputs("reset");
    reset = 1'b0;
    bus.enable = 1'b0;
    @(negedge clock);
    nrd = 0;
    bus.addr = 32'h103;
    bus.funct3 = LB;
    bus.enable = 1'b1;
    repeat (2) @(negedge clock);
    chk("lb_cmp", 32'(bus.is_complete), 32'h1);
    chk("lb_val", bus.load_val, 32'hFFFFFF88);
    chk("lb_rd_addr", rd0, 32'h100);
    chk("lb_reads", 32'(nrd), 32'h1);
    @(negedge clock);
    chk("lb_hold_cmp", 32'(bus.is_complete), 32'h1);
    chk("lb_hold_val", bus.load_val, 32'hFFFFFF88);
    chk("lb_done_re", 32'(bus.mem_read_enable), 32'h0);
    bus.enable = 1'b0;
    @(negedge clock);
    chk("lb_back_idle", 32'(bus.is_complete), 32'h0);
    load("lbu", 32'h103, LBU, 32'h00000088, 1'b0, 2, 1);
    load("lhu", 32'h102, LHU, 32'h00008877, 1'b0, 2, 1);
    load("lh", 32'h100, LH, 32'h00006655, 1'b0, 2, 1);
    load("lw_al", 32'h104, LW, 32'hCCBBAA99, 1'b0, 2, 1);
`ifdef LOAD_UNIT_MISALIGNED_EN
    load("lw_cross", 32'h102, LW, 32'hAA998877, 1'b0, 4, 2);
    chk("lw_cross_rd0", rd0, 32'h100);
    chk("lw_cross_rd1", rd1, 32'h104);
`else
    load("lw_cross", 32'h102, LW, 32'h0, 1'b1, 2, 1);
    chk("lw_cross_rd0", rd0, 32'h100);
`endif
    re_seen = 1'b0;
    load("illegal", 32'h100, 3'b011, 32'h0, 1'b1, 1, 0);
    chk("illegal_no_re", 32'(re_seen), 32'h0);
    bus.addr = 32'h100;
    bus.funct3 = LW;
    bus.enable = 1'b1;
    @(negedge clock);
    chk("abort_wait_re", 32'(bus.mem_read_enable), 32'h1);
    chk("abort_wait_addr", bus.mem_addr, 32'h100);
    comp_seen = 1'b0;
    bus.enable = 1'b0;
    @(negedge clock);
    chk("abort_re", 32'(bus.mem_read_enable), 32'h0);
    chk("abort_addr", bus.mem_addr, 32'h0);
    repeat (3) @(negedge clock);
    chk("abort_no_cmp", 32'(comp_seen), 32'h0);
    load("after_abort", 32'h104, LW, 32'hCCBBAA99, 1'b0, 2, 1);
    bus.addr = 32'h102;
    bus.funct3 = LW;
    bus.enable = 1'b1;
    repeat (2) @(negedge clock);
`ifdef LOAD_UNIT_MISALIGNED_EN
    chk("hi_wait_addr", bus.mem_addr, 32'h104);
`endif
    reset = 1'b1;
    @(negedge clock);
    chk_idle_outputs("mid_reset");
    reset = 1'b0;
    bus.enable = 1'b0;
    @(negedge clock);
`ifdef LOAD_UNIT_MISALIGNED_EN
    load("wrap", 32'hFFFFFFFE, LH, 32'h00001234, 1'b0, 2, 1);
    load("wrap_x", 32'hFFFFFFFE, LW, 32'hDEF01234, 1'b0, 4, 2);
    chk("wrap_rd1", rd1, 32'h0);
`else
    load("wrap", 32'hFFFFFFFE, LH, 32'h00001234, 1'b0, 2, 1);
    load("wrap_x", 32'hFFFFFFFE, LW, 32'h0, 1'b1, 2, 1);
`endif
    chk("wrap_rd0", rd0, 32'hFFFFFFFC);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
